// File: rtl/tdm_pkg.sv
// Shared TDM definitions: lane count, select width and receive FSM states.
package tdm_pkg;
  localparam int LANES = 4;
  localparam int SEL_W = 2;

  typedef enum logic {HUNT, LOCKED} demux_state_t;
endpackage

// File: rtl/slot_counter.sv
// Mod-4 slot index with clear, load-to-1 and increment; wrap flags the 3->0 step.
module slot_counter
  import tdm_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             load1_i,
  input  logic             inc_i,
  output logic [SEL_W-1:0] cnt_o,
  output logic             wrap_o
);
  logic [SEL_W-1:0] cnt_q, cnt_d;

  // Clear beats load, load beats increment.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)        cnt_d = '0;
    else if (load1_i) cnt_d = SEL_W'(1);
    else if (inc_i)   cnt_d = cnt_q + SEL_W'(1);
  end

  assign wrap_o = inc_i & ~load1_i & ~clr_i & (cnt_q == SEL_W'(LANES - 1));
  assign cnt_o  = cnt_q;

  // Counter register.
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
endmodule

// File: rtl/tdm_demux_1x4.sv
// 1:4 TDM demultiplexer: aligns on sync, assembles four slots, emits a registered frame.
module tdm_demux_1x4
  import tdm_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [WIDTH-1:0]       Y,
  input  logic                   sync,
  input  logic                   en,
  output logic [LANES*WIDTH-1:0] in,
  output logic [SEL_W-1:0]       S,
  output logic                   valid,
  output logic                   sync_err
);
  // Slot 3 never needs a shadow: it goes straight into the output word.
  typedef logic [LANES-2:0][WIDTH-1:0] shadow_t;

  demux_state_t             state_q, state_d;
  shadow_t                  shadow_q, shadow_d;
  logic [LANES*WIDTH-1:0]   in_q, in_d;
  logic                     valid_q, err_q, err_d;
  logic                     clr, load1, inc, wrap;
  logic [SEL_W-1:0]         slot;

  slot_counter u_slot (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (clr),
    .load1_i (load1),
    .inc_i   (inc),
    .cnt_o   (slot),
    .wrap_o  (wrap)
  );

  // Next-state, shadow capture, frame assembly and error detection.
  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    in_d     = in_q;
    err_d    = 1'b0;
    clr      = 1'b0;
    load1    = 1'b0;
    inc      = 1'b0;
    case (state_q)
      HUNT: begin
        if (en && sync) begin
          shadow_d[0] = Y;
          load1       = 1'b1;
          state_d     = LOCKED;
        end
      end
      LOCKED: begin
        if (en) begin
          if (sync) begin
            // Sync anywhere but slot 0 restarts the frame at this sample.
            err_d       = (slot != '0);
            shadow_d[0] = Y;
            load1       = 1'b1;
          end else if (slot == '0) begin
            // Expected a frame marker; alignment is lost.
            err_d   = 1'b1;
            clr     = 1'b1;
            state_d = HUNT;
          end else begin
            inc = 1'b1;
            for (int k = 1; k < LANES - 1; k++)
              if (slot == SEL_W'(k)) shadow_d[k] = Y;
            if (slot == SEL_W'(LANES - 1)) in_d = {Y, shadow_q};
          end
        end
      end
      default: begin
        state_d = HUNT;
        clr     = 1'b1;
      end
    endcase
  end

  // State, shadow lanes and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= HUNT;
      shadow_q <= '0;
      in_q     <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      in_q     <= in_d;
      valid_q  <= wrap;
      err_q    <= err_d;
    end
  end

  assign in       = in_q;
  assign S        = slot;
  assign valid    = valid_q;
  assign sync_err = err_q;
endmodule

// File: tb/tb_tdm_demux_1x4.sv
// Scoreboard bench for tdm_demux_1x4 (WIDTH=1): expected frames queued at drive time.
module tb_tdm_demux_1x4;
  localparam int W = 1;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] Y = '0;
  logic         sync = 1'b0;
  logic         en = 1'b0;
  logic [4*W-1:0] in;
  logic [1:0]   S;
  logic         valid;
  logic         sync_err;

  int n_chk = 0, n_pass = 0;
  int cyc = 0, err_seen = 0, exp_err = 0;
  logic [3:0] exp_q[$];
  int vcyc[$];

  tdm_demux_1x4 #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .Y(Y), .sync(sync), .en(en),
    .in(in), .S(S), .valid(valid), .sync_err(sync_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Scoreboard monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (valid && sync_err) chk("valid_err_excl", 1, 0);
    if (sync_err) err_seen++;
    if (valid) begin
      vcyc.push_back(cyc);
      if (exp_q.size() == 0) chk("valid_spurious", {28'd0, in}, 32'hFFFF_FFFF);
      else chk("frame", {28'd0, in}, {28'd0, exp_q.pop_front()});
    end
  end

  // Drive one cycle; returns just after the edge that samples it.
  task automatic step(input logic r, input logic e, input logic s, input logic [W-1:0] y);
    rst = r; en = e; sync = s; Y = y;
    @(posedge clk); #1;
    rst = 1'b0; en = 1'b0; sync = 1'b0;
  endtask

  task automatic frame(input logic [3:0] d);
    step(0, 1, 1, d[0]);
    step(0, 1, 0, d[1]);
    step(0, 1, 0, d[2]);
    exp_q.push_back(d);
    step(0, 1, 0, d[3]);
  endtask

  initial begin
    logic [3:0] rd;
    logic [3:0] onehot;
    int e0;

    // Reset state
    step(1, 0, 0, 0);
    step(1, 1, 1, 1);
    chk("rst_in", in, 0); chk("rst_S", S, 0);
    chk("rst_valid", valid, 0); chk("rst_err", sync_err, 0);

    // Basic frame 1,0,1,1 -> 4'b1101
    frame(4'b1101);
    chk("f1_valid", valid, 1); chk("f1_in", in, 4'b1101);
    chk("f1_S", S, 0); chk("f1_err", sync_err, 0);
    step(0, 0, 0, 0);
    chk("f1_pulse", valid, 0);

    // Back-to-back one-hot frames, valid every 4 cycles
    vcyc.delete();
    for (int k = 0; k < 4; k++) begin
      onehot = 4'b0001 << k;
      frame(onehot);
    end
    step(0, 0, 0, 0);
    chk("oh_count", vcyc.size(), 4);
    for (int k = 1; k < vcyc.size(); k++) chk("oh_spacing", vcyc[k] - vcyc[k-1], 4);

    // Frame complete, then a strobe with no sync -> error, HUNT, in holds
    frame(4'b1101);
    exp_err++;
    step(0, 1, 0, 1);
    chk("miss_err", sync_err, 1); chk("miss_S", S, 0); chk("miss_in", in, 4'b1101);
    step(0, 1, 0, 1);
    chk("miss_err_once", sync_err, 0); chk("miss_hunt_S", S, 0);

    // After reset, HUNT ignores unsynced strobes
    step(1, 0, 0, 0);
    for (int k = 0; k < 5; k++) begin
      step(0, 1, 0, 1);
      chk("hunt_S", S, 0); chk("hunt_in", in, 0);
      chk("hunt_valid", valid, 0); chk("hunt_err", sync_err, 0);
    end

    // Early sync at S=2 restarts the frame
    frame(4'b1101);
    step(0, 1, 1, 0);
    step(0, 1, 0, 0);
    chk("late_preS", S, 2);
    exp_err++;
    step(0, 1, 1, 1);
    chk("late_err", sync_err, 1); chk("late_S", S, 1); chk("late_in", in, 4'b1101);
    step(0, 1, 0, 0);
    step(0, 1, 0, 0);
    exp_q.push_back(4'b0001);
    step(0, 1, 0, 0);
    chk("late_valid", valid, 1); chk("late_frame_in", in, 4'b0001);

    // Sync at S=3 yields error only, no frame
    step(0, 1, 1, 1); step(0, 1, 0, 1); step(0, 1, 0, 1);
    exp_err++;
    step(0, 1, 1, 0);
    chk("s3_err", sync_err, 1); chk("s3_valid", valid, 0);
    chk("s3_S", S, 1); chk("s3_in", in, 4'b0001);
    step(0, 1, 0, 1); step(0, 1, 0, 0);
    exp_q.push_back(4'b1010);
    step(0, 1, 0, 1);

    // Frame assembled across en gaps
    step(0, 1, 1, 0);
    step(0, 0, 1, 1); step(0, 0, 0, 1);
    chk("gap_S", S, 1); chk("gap_in", in, 4'b1010);
    step(0, 1, 0, 1);
    step(0, 0, 0, 0);
    step(0, 1, 0, 1);
    step(0, 0, 0, 0); step(0, 0, 0, 0);
    chk("gap_S3", S, 3);
    exp_q.push_back(4'b0110);
    step(0, 1, 0, 0);
    chk("gap_valid", valid, 1);

    // Reset mid-frame clears output; capture needs a fresh sync
    step(0, 1, 1, 1); step(0, 1, 0, 1);
    chk("rmid_S", S, 2);
    step(1, 1, 0, 1);
    chk("rmid_in", in, 0); chk("rmid_S0", S, 0); chk("rmid_valid", valid, 0);
    step(0, 1, 0, 1); step(0, 1, 0, 1);
    chk("rmid_hunt_S", S, 0);
    frame(4'b0111);
    chk("rmid_resume", in, 4'b0111);

    // Random frames with random idle gaps
    for (int f = 0; f < 20; f++) begin
      rd = 4'($urandom_range(0, 15));
      for (int k = 0; k < 4; k++) begin
        if ($urandom_range(0, 3) == 0) step(0, 0, $urandom_range(0, 1), 1);
        if (k == 3) exp_q.push_back(rd);
        step(0, 1, (k == 0), rd[k]);
      end
    end

    step(0, 0, 0, 0); step(0, 0, 0, 0);
    chk("sb_empty", exp_q.size(), 0);
    chk("err_total", err_seen, exp_err);
    e0 = n_chk;
    chk("checks_made", (e0 >= 12), 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
